// File: rtl/matmul_pkg.sv
// Shared types for the matmul job arbiter: FSM states,
// matrix size pair, job descriptor and watchdog limit.
package matmul_pkg;

    localparam int MM_SIZE_COUNT = 8;
    localparam int MM_SIZE_WIDTH = $clog2(MM_SIZE_COUNT);
    localparam int MM_ADDR_WIDTH = 32;

    localparam logic [15:0] WDOG_MAX = 16'hFFFF;

    typedef enum logic [2:0] {
        IDLE,
        GRANT,
        CHECK,
        START,
        WAIT_HI,
        RUN,
        RESP
    } arb_state_t;

    typedef struct packed {
        logic [MM_SIZE_WIDTH-1:0] rows;
        logic [MM_SIZE_WIDTH-1:0] cols;
    } mat_size_t;

    typedef struct packed {
        mat_size_t                a_size;
        mat_size_t                b_size;
        logic [MM_ADDR_WIDTH-1:0] a_base;
        logic [MM_ADDR_WIDTH-1:0] b_base;
        logic [MM_ADDR_WIDTH-1:0] c_base;
    } job_desc_t;

endpackage

// File: rtl/matmul_job_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping.
// Ports: req, ptr in; one-hot grant, grant_idx, any out.
module rr_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int REQ_WIDTH = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0]   req,
    input  logic [REQ_WIDTH-1:0] ptr,
    output logic [NUM_REQ-1:0]   grant,
    output logic [REQ_WIDTH-1:0] grant_idx,
    output logic                 any
);

    always_comb begin
        int j;
        j         = 0;
        grant     = '0;
        grant_idx = '0;
        any       = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            j = (int'(ptr) + i) % NUM_REQ;
            if (!any && req[j]) begin
                any       = 1'b1;
                grant[j]  = 1'b1;
                grant_idx = REQ_WIDTH'(j);
            end
        end
    end

endmodule

// File: rtl/matmul_job_arbiter.sv
// Shares one matrix_multiply engine among NUM_REQ job queues, one job at a time.
// Ports: req_* descriptors/handshake in, rsp_done/rsp_error out, eng_* to engine,
// grant_id/arb_busy status. MATMUL_ARB_WATCHDOG_EN adds a 16-bit busy watchdog
// and the sticky wdog_fired output.
module matmul_job_arbiter
    import matmul_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int SIZE_COUNT = MM_SIZE_COUNT,
    parameter int SIZE_WIDTH = $clog2(SIZE_COUNT),
    parameter int ADDR_WIDTH = MM_ADDR_WIDTH,
    parameter int REQ_WIDTH  = $clog2(NUM_REQ)
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic [NUM_REQ-1:0]                   req_valid,
    output logic [NUM_REQ-1:0]                   req_ready,
    input  logic [NUM_REQ-1:0][2*SIZE_WIDTH-1:0] req_a_size,
    input  logic [NUM_REQ-1:0][2*SIZE_WIDTH-1:0] req_b_size,
    input  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]   req_a_base,
    input  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]   req_b_base,
    input  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]   req_c_base,
    output logic [NUM_REQ-1:0]                   rsp_done,
    output logic                                 rsp_error,
    output logic                                 eng_start,
    output logic [2*SIZE_WIDTH-1:0]              eng_a_size,
    output logic [2*SIZE_WIDTH-1:0]              eng_b_size,
    output logic [ADDR_WIDTH-1:0]                eng_a_base,
    output logic [ADDR_WIDTH-1:0]                eng_b_base,
    output logic [ADDR_WIDTH-1:0]                eng_c_base,
    input  logic                                 eng_busy,
`ifdef MATMUL_ARB_WATCHDOG_EN
    output logic                                 wdog_fired,
`endif
    output logic [REQ_WIDTH-1:0]                 grant_id,
    output logic                                 arb_busy
);

    arb_state_t           state, state_nxt;
    logic [REQ_WIDTH-1:0] rr_ptr;
    logic [REQ_WIDTH-1:0] gnt_idx;
    logic [REQ_WIDTH-1:0] grant_q;
    logic [NUM_REQ-1:0]   gnt_oh;
    logic [NUM_REQ-1:0]   grant_oh_q;
    logic                 gnt_any;
    job_desc_t            desc_q;
    logic                 err_q;
    logic                 size_ok;
    logic                 wdog_hit;
    logic                 waiting;

    rr_arbiter #(
        .NUM_REQ  (NUM_REQ),
        .REQ_WIDTH(REQ_WIDTH)
    ) u_rr (
        .req      (req_valid),
        .ptr      (rr_ptr),
        .grant    (gnt_oh),
        .grant_idx(gnt_idx),
        .any      (gnt_any)
    );

    assign size_ok = (desc_q.a_size.cols == desc_q.b_size.rows);
    assign waiting = (state == WAIT_HI) || (state == RUN);

`ifdef MATMUL_ARB_WATCHDOG_EN
    logic [15:0] wdog_cnt;
    logic        wdog_fired_q;

    assign wdog_hit   = waiting && (wdog_cnt == WDOG_MAX);
    assign wdog_fired = wdog_fired_q;

    // Restart the count on every entry into a wait state (WAIT_HI->RUN too).
    always_ff @(posedge clk) begin
        if (reset) begin
            wdog_cnt     <= '0;
            wdog_fired_q <= 1'b0;
        end else begin
            if ((state_nxt == WAIT_HI || state_nxt == RUN) && state_nxt != state)
                wdog_cnt <= '0;
            else if (waiting)
                wdog_cnt <= wdog_cnt + 16'd1;
            if (wdog_hit)
                wdog_fired_q <= 1'b1;
        end
    end
`else
    assign wdog_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (gnt_any) state_nxt = GRANT;
            GRANT:   state_nxt = CHECK;
            CHECK:   state_nxt = size_ok ? START : RESP;
            START:   state_nxt = WAIT_HI;
            WAIT_HI: begin
                if (wdog_hit)      state_nxt = RESP;
                else if (eng_busy) state_nxt = RUN;
            end
            RUN: begin
                if (wdog_hit || !eng_busy) state_nxt = RESP;
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        req_ready = '0;
        rsp_done  = '0;
        rsp_error = 1'b0;
        eng_start = 1'b0;
        unique case (state)
            GRANT: req_ready = grant_oh_q;
            START: eng_start = 1'b1;
            RESP: begin
                rsp_done  = grant_oh_q;
                rsp_error = err_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr     <= '0;
            grant_q    <= '0;
            grant_oh_q <= '0;
            desc_q     <= '0;
            err_q      <= 1'b0;
        end else begin
            if (state == IDLE && gnt_any) begin
                grant_q    <= gnt_idx;
                grant_oh_q <= gnt_oh;
                err_q      <= 1'b0;
            end
            if (state == GRANT) begin
                desc_q.a_size <= req_a_size[grant_q];
                desc_q.b_size <= req_b_size[grant_q];
                desc_q.a_base <= req_a_base[grant_q];
                desc_q.b_base <= req_b_base[grant_q];
                desc_q.c_base <= req_c_base[grant_q];
            end
            if ((state == CHECK && !size_ok) || wdog_hit)
                err_q <= 1'b1;
            if (state == RESP)
                rr_ptr <= (grant_q == REQ_WIDTH'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
        end
    end

    assign grant_id   = grant_q;
    assign arb_busy   = (state != IDLE);
    assign eng_a_size = desc_q.a_size;
    assign eng_b_size = desc_q.b_size;
    assign eng_a_base = desc_q.a_base;
    assign eng_b_base = desc_q.b_base;
    assign eng_c_base = desc_q.c_base;

endmodule

// File: tb/tb_matmul_job_arbiter.sv
// Scoreboard bench for matmul_job_arbiter with a simple busy-engine model.
module tb_matmul_job_arbiter;
    import matmul_pkg::*;

    localparam int N  = 4;
    localparam int SW = 3;
    localparam int AW = 32;
    localparam int RW = 2;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic [N-1:0]           req_valid;
    logic [N-1:0]           req_ready;
    logic [N-1:0][2*SW-1:0] req_a_size, req_b_size;
    logic [N-1:0][AW-1:0]   req_a_base, req_b_base, req_c_base;
    logic [N-1:0]           rsp_done;
    logic                   rsp_error;
    logic                   eng_start;
    logic [2*SW-1:0]        eng_a_size, eng_b_size;
    logic [AW-1:0]          eng_a_base, eng_b_base, eng_c_base;
    logic                   eng_busy;
    logic [RW-1:0]          grant_id;
    logic                   arb_busy;
`ifdef MATMUL_ARB_WATCHDOG_EN
    logic                   wdog_fired;
`endif

    matmul_job_arbiter #(.NUM_REQ(N)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a_size(req_a_size),
        .req_b_size(req_b_size),
        .req_a_base(req_a_base),
        .req_b_base(req_b_base),
        .req_c_base(req_c_base),
        .rsp_done  (rsp_done),
        .rsp_error (rsp_error),
        .eng_start (eng_start),
        .eng_a_size(eng_a_size),
        .eng_b_size(eng_b_size),
        .eng_a_base(eng_a_base),
        .eng_b_base(eng_b_base),
        .eng_c_base(eng_c_base),
        .eng_busy  (eng_busy),
`ifdef MATMUL_ARB_WATCHDOG_EN
        .wdog_fired(wdog_fired),
`endif
        .grant_id  (grant_id),
        .arb_busy  (arb_busy)
    );

    typedef struct {
        int idx;
        bit err;
    } rsp_t;

    int        gq[$];
    rsp_t      rq[$];
    job_desc_t sq[$];

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int busy_len = 20;
    bit stuck = 1'b0;
    int fall_cyc = 0;
    int ready_cyc = 0;
    int n_start = 0;
    int n_done = 0;
    int outstanding = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic job_desc_t mk(input int i);
        job_desc_t d;
        d.a_size = req_a_size[i];
        d.b_size = req_b_size[i];
        d.a_base = req_a_base[i];
        d.b_base = req_b_base[i];
        d.c_base = req_c_base[i];
        return d;
    endfunction

    task automatic setd(input int i, input int ar, input int ac, input int br,
                        input int bc, input logic [AW-1:0] base);
        req_a_size[i] = {3'(ar), 3'(ac)};
        req_b_size[i] = {3'(br), 3'(bc)};
        req_a_base[i] = base;
        req_b_base[i] = base + 32'h100;
        req_c_base[i] = base + 32'h200;
    endtask

    task automatic push_job(input int i, input bit err);
        rsp_t r;
        gq.push_back(i);
        if (!err) sq.push_back(mk(i));
        r.idx = i;
        r.err = err;
        rq.push_back(r);
    endtask

    task automatic run(input logic [N-1:0] mask, input int n, input int bound);
        int target;
        target = n_done + n;
        req_valid = mask;
        for (int k = 0; k < bound && n_done < target; k++) begin
            @(negedge clk);
            #1;
        end
        chk("jobs_done", 128'(n_done), 128'(target));
        req_valid = '0;
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_req_ready"}, 128'(req_ready), 0);
        chk({tag, "_rsp_done"}, 128'(rsp_done), 0);
        chk({tag, "_rsp_error"}, 128'(rsp_error), 0);
        chk({tag, "_eng_start"}, 128'(eng_start), 0);
        chk({tag, "_eng_sizes"}, 128'({eng_a_size, eng_b_size}), 0);
        chk({tag, "_eng_bases"}, 128'({eng_a_base, eng_b_base, eng_c_base}), 0);
        chk({tag, "_grant_id"}, 128'(grant_id), 0);
        chk({tag, "_arb_busy"}, 128'(arb_busy), 0);
    endtask

    // Engine model: busy rises the cycle after start, stays busy_len cycles.
    initial begin
        int cnt;
        bit pend;
        cnt = 0;
        pend = 1'b0;
        eng_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                eng_busy = 1'b0;
                pend = 1'b0;
            end else if (eng_start) begin
                pend = 1'b1;
            end else if (pend) begin
                pend = 1'b0;
                eng_busy = 1'b1;
                cnt = busy_len;
            end else if (eng_busy && !stuck) begin
                cnt--;
                if (cnt == 0) begin
                    eng_busy = 1'b0;
                    fall_cyc = cyc;
                end
            end
        end
    end

    // Monitor: pops scoreboard entries whenever the DUT presents an event.
    initial begin
        int e;
        rsp_t r;
        job_desc_t d;
        forever begin
            @(negedge clk);
            if (req_ready != '0) begin
                if (gq.size() == 0) begin
                    chk("unexpected_grant", 128'(req_ready), 0);
                end else begin
                    e = gq.pop_front();
                    chk("grant_onehot", 128'(req_ready), 128'(1) << e);
                    chk("grant_id", 128'(grant_id), 128'(e));
                    chk("no_overlap", 128'(outstanding), 0);
                end
                outstanding++;
                ready_cyc = cyc;
            end
            if (eng_start) begin
                n_start++;
                if (sq.size() == 0) begin
                    chk("unexpected_start", 128'(eng_start), 0);
                end else begin
                    d = sq.pop_front();
                    chk("start_latency", 128'(cyc), 128'(ready_cyc + 2));
                    chk("start_desc", 128'({eng_a_size, eng_b_size, eng_a_base,
                                            eng_b_base, eng_c_base}), 128'(d));
                end
            end
            if (rsp_done != '0) begin
                if (rq.size() == 0) begin
                    chk("unexpected_done", 128'(rsp_done), 0);
                end else begin
                    r = rq.pop_front();
                    chk("rsp_done", 128'(rsp_done), 128'(1) << r.idx);
                    chk("rsp_error", 128'(rsp_error), 128'(r.err));
                    if (!r.err) chk("done_latency", 128'(cyc), 128'(fall_cyc + 1));
                end
                outstanding--;
                n_done++;
            end
        end
    end

    initial begin
        int order[8] = '{0, 1, 2, 3, 0, 1, 2, 3};
        int s0;
        req_valid = '0;
        for (int i = 0; i < N; i++) setd(i, 0, 0, 0, 0, 32'h0);

        repeat (3) @(negedge clk);
        chk_idle_outputs("reset");
`ifdef MATMUL_ARB_WATCHDOG_EN
        chk("reset_wdog_fired", 128'(wdog_fired), 0);
`endif
        reset = 1'b0;

        // Single good job, A 4x3 * B 3x5.
        setd(0, 4, 3, 3, 5, 32'h1000);
        push_job(0, 1'b0);
        run(4'b0001, 1, 200);

        // Dimension mismatch: engine must not start.
        setd(0, 4, 3, 2, 5, 32'h2000);
        s0 = n_start;
        push_job(0, 1'b1);
        run(4'b0001, 1, 100);
        chk("mismatch_no_start", 128'(n_start), 128'(s0));
        chk("mismatch_eng_idle", 128'(eng_busy), 0);

        // Reset while RUN: job abandoned, no done.
        setd(2, 2, 2, 2, 2, 32'h3000);
        gq.push_back(2);
        sq.push_back(mk(2));
        req_valid = 4'b0100;
        for (int k = 0; k < 50 && !eng_busy; k++) @(negedge clk);
        req_valid = '0;
        chk("reached_run", 128'(eng_busy), 1);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk_idle_outputs("midrst");
        #1;
        reset = 1'b0;
        outstanding = 0;
        repeat (30) @(negedge clk);

        // Pointer back to 0: with 0 and 3 pending, 0 goes first.
        busy_len = 4;
        setd(0, 1, 1, 1, 1, 32'h4000);
        setd(3, 3, 3, 3, 3, 32'h5000);
        push_job(0, 1'b0);
        push_job(3, 1'b0);
        run(4'b1001, 2, 200);

        // Round robin, all held valid, max legal sizes on req3.
        busy_len = 3;
        setd(0, 1, 2, 2, 1, 32'h10000);
        setd(1, 2, 3, 3, 4, 32'h20000);
        setd(2, 5, 6, 6, 7, 32'h30000);
        setd(3, 7, 7, 7, 7, 32'h40000);
        for (int k = 0; k < 8; k++) push_job(order[k], 1'b0);
        run(4'b1111, 8, 600);

        // Move pointer to 3, then only req1: wrap and skip.
        push_job(2, 1'b0);
        run(4'b0100, 1, 100);
        push_job(1, 1'b0);
        run(4'b0010, 1, 100);
        // Pointer now 2: with 0 and 2 pending, 2 wins.
        push_job(2, 1'b0);
        run(4'b0101, 1, 100);

`ifdef MATMUL_ARB_WATCHDOG_EN
        stuck = 1'b1;
        setd(1, 2, 2, 2, 2, 32'h6000);
        push_job(1, 1'b1);
        sq.push_back(mk(1));
        run(4'b0010, 1, 70000);
        chk("wdog_fired", 128'(wdog_fired), 1);
`endif

        repeat (5) @(negedge clk);
        chk("queues_empty", 128'(gq.size() + rq.size() + sq.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
